// File: rtl/regfile_scoreboard.sv
// Integer register file with write-through read bypass and a busy scoreboard
// for long-latency (MUL/DIV) destinations. x0 is hardwired to zero.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   rs_addr / rs_data     NRD packed read ports (combinational, bypassed)
//   rs_busy               per read port: operand still pending
//   wr0_*                 write port 0, single-cycle ALU/load writeback
//   wr1_*                 write port 1, MUL/DIV completion (clears busy)
//   iss_en / iss_rd       long-latency issue, marks iss_rd busy
//   iss_ok                iss_rd is free this cycle (issue accepted)
//   busy_cnt              registered count of busy registers
//   wr_conflict           sticky: both write ports hit the same nonzero rd
module regfile_scoreboard #(
    parameter int unsigned XLEN       = 64,
    parameter int unsigned NREGS      = 32,
    parameter int unsigned NRD        = 2,
    parameter int unsigned INIT_INDEX = 1,
    localparam int unsigned AW        = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rs_addr,
    output logic [NRD*XLEN-1:0] rs_data,
    output logic [NRD-1:0]      rs_busy,
    input  logic                wr0_en,
    input  logic [AW-1:0]       wr0_rd,
    input  logic [XLEN-1:0]     wr0_data,
    input  logic                wr1_en,
    input  logic [AW-1:0]       wr1_rd,
    input  logic [XLEN-1:0]     wr1_data,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_rd,
    output logic                iss_ok,
    output logic [AW:0]         busy_cnt,
    output logic                wr_conflict
);

    localparam int unsigned CW = AW + 1;

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;

    logic wr0_hit;
    logic wr1_hit;
    logic sb_set;
    logic sb_clr;
    logic cnt_inc;
    logic cnt_dec;

    // A completion landing in the same cycle frees the register for re-issue.
    assign iss_ok  = (iss_rd == '0) || !busy[iss_rd] || (wr1_en && (wr1_rd == iss_rd));

    assign wr0_hit = wr0_en && (wr0_rd != '0);
    assign wr1_hit = wr1_en && (wr1_rd != '0);
    assign sb_set  = iss_en && iss_ok && (iss_rd != '0);
    assign sb_clr  = wr1_hit;

    // Counter deltas from actual bit transitions; set wins over clear.
    assign cnt_inc = sb_set && !busy[iss_rd];
    assign cnt_dec = sb_clr && busy[wr1_rd] && !(sb_set && (iss_rd == wr1_rd));

    // Read ports: x0, then port 1 bypass, then port 0 bypass, then storage.
    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] a;
        assign a = rs_addr[k*AW +: AW];
        assign rs_data[k*XLEN +: XLEN] =
            (a == '0)                   ? '0       :
            (wr1_en && (wr1_rd == a))   ? wr1_data :
            (wr0_en && (wr0_rd == a))   ? wr0_data :
                                          regs[a];
        assign rs_busy[k] = busy[a] && !(wr1_en && (wr1_rd == a));
    end

    // Storage; port 1 is written last so it wins a same-rd collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[AW'(i)] <= (INIT_INDEX != 0) ? XLEN'(i) : '0;
            end
        end else begin
            if (wr0_hit) begin
                regs[wr0_rd] <= wr0_data;
            end
            if (wr1_hit) begin
                regs[wr1_rd] <= wr1_data;
            end
        end
    end

    // Scoreboard bits, busy counter and sticky conflict flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy        <= '0;
            busy_cnt    <= '0;
            wr_conflict <= 1'b0;
        end else begin
            if (sb_clr) begin
                busy[wr1_rd] <= 1'b0;
            end
            if (sb_set) begin
                busy[iss_rd] <= 1'b1;
            end
            busy_cnt <= busy_cnt + CW'(cnt_inc) - CW'(cnt_dec);
            if (wr0_hit && wr1_hit && (wr0_rd == wr1_rd)) begin
                wr_conflict <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
module tb_regfile_scoreboard;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned NREGS = 32;
    localparam int unsigned NRD   = 2;
    localparam int unsigned AW    = 5;

    logic                clk = 1'b0;
    logic                rst;
    logic [NRD*AW-1:0]   rs_addr;
    logic [NRD*XLEN-1:0] rs_data;
    logic [NRD-1:0]      rs_busy;
    logic                wr0_en;
    logic [AW-1:0]       wr0_rd;
    logic [XLEN-1:0]     wr0_data;
    logic                wr1_en;
    logic [AW-1:0]       wr1_rd;
    logic [XLEN-1:0]     wr1_data;
    logic                iss_en;
    logic [AW-1:0]       iss_rd;
    logic                iss_ok;
    logic [AW:0]         busy_cnt;
    logic                wr_conflict;

    regfile_scoreboard #(
        .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .INIT_INDEX(1)
    ) dut (
        .clk(clk), .rst(rst),
        .rs_addr(rs_addr), .rs_data(rs_data), .rs_busy(rs_busy),
        .wr0_en(wr0_en), .wr0_rd(wr0_rd), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_rd(wr1_rd), .wr1_data(wr1_data),
        .iss_en(iss_en), .iss_rd(iss_rd), .iss_ok(iss_ok),
        .busy_cnt(busy_cnt), .wr_conflict(wr_conflict)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: architectural state as plain arrays.
    logic [XLEN-1:0] m_mem  [NREGS];
    bit              m_busy [NREGS];
    bit              m_conf;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NREGS; i++) begin
            m_mem[i]  = 64'(i);
            m_busy[i] = 1'b0;
        end
        m_conf = 1'b0;
    endfunction

    function automatic logic [63:0] m_read(input int a);
        if (a == 0) return 64'h0;
        if (wr1_en && int'(wr1_rd) == a) return wr1_data;
        if (wr0_en && int'(wr0_rd) == a) return wr0_data;
        return m_mem[a];
    endfunction

    function automatic bit m_rbusy(input int a);
        if (wr1_en && int'(wr1_rd) == a) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic bit m_issok();
        int r = int'(iss_rd);
        if (r == 0) return 1'b1;
        if (!m_busy[r]) return 1'b1;
        return wr1_en && int'(wr1_rd) == r;
    endfunction

    function automatic int m_cnt();
        int n = 0;
        for (int i = 0; i < NREGS; i++) n += int'(m_busy[i]);
        return n;
    endfunction

    function automatic void model_edge();
        bit ok;
        if (rst) begin
            model_reset();
            return;
        end
        ok = m_issok();
        if (wr0_en && wr0_rd != 0) m_mem[wr0_rd] = wr0_data;
        if (wr1_en && wr1_rd != 0) begin
            m_mem[wr1_rd]  = wr1_data;
            m_busy[wr1_rd] = 1'b0;
            if (wr0_en && wr0_rd == wr1_rd) m_conf = 1'b1;
        end
        if (iss_en && ok && iss_rd != 0) m_busy[iss_rd] = 1'b1;
    endfunction

    task automatic drive(input bit r, input bit w0e, input int w0r, input logic [63:0] w0d,
                         input bit w1e, input int w1r, input logic [63:0] w1d,
                         input bit ie, input int ir, input int a0, input int a1);
        rst      = r;
        wr0_en   = w0e; wr0_rd = AW'(w0r); wr0_data = w0d;
        wr1_en   = w1e; wr1_rd = AW'(w1r); wr1_data = w1d;
        iss_en   = ie;  iss_rd = AW'(ir);
        rs_addr  = {AW'(a1), AW'(a0)};
    endtask

    // One model-checked cycle: combinational outputs, edge, registered outputs.
    task automatic cyc(input bit r, input bit w0e, input int w0r, input logic [63:0] w0d,
                       input bit w1e, input int w1r, input logic [63:0] w1d,
                       input bit ie, input int ir, input int a0, input int a1);
        drive(r, w0e, w0r, w0d, w1e, w1r, w1d, ie, ir, a0, a1);
        #1;
        chk("rd0",    rs_data[63:0],   m_read(a0));
        chk("rd1",    rs_data[127:64], m_read(a1));
        chk("rbusy0", 64'(rs_busy[0]), 64'(m_rbusy(a0)));
        chk("rbusy1", 64'(rs_busy[1]), 64'(m_rbusy(a1)));
        chk("iss_ok", 64'(iss_ok),     64'(m_issok()));
        @(posedge clk);
        model_edge();
        #1;
        chk("busy_cnt", 64'(busy_cnt),    64'(m_cnt()));
        chk("conflict", 64'(wr_conflict), 64'(m_conf));
        @(negedge clk);
    endtask

    typedef struct {
        bit          w0en; int w0rd; logic [63:0] w0d;
        bit          w1en; int w1rd; logic [63:0] w1d;
        bit          isen; int isrd;
        int          a0;   int a1;
        logic [63:0] ed0;  logic [63:0] ed1;
        bit          eb0;  bit eb1;  bit eok;
        int          ecnt; bit econf;
    } vec_t;

    function automatic vec_t mk(input bit w0en, input int w0rd, input logic [63:0] w0d,
                                input bit w1en, input int w1rd, input logic [63:0] w1d,
                                input bit isen, input int isrd, input int a0, input int a1,
                                input logic [63:0] ed0, input logic [63:0] ed1,
                                input bit eb0, input bit eb1, input bit eok,
                                input int ecnt, input bit econf);
        vec_t v;
        v.w0en = w0en; v.w0rd = w0rd; v.w0d = w0d;
        v.w1en = w1en; v.w1rd = w1rd; v.w1d = w1d;
        v.isen = isen; v.isrd = isrd; v.a0 = a0; v.a1 = a1;
        v.ed0 = ed0; v.ed1 = ed1; v.eb0 = eb0; v.eb1 = eb1; v.eok = eok;
        v.ecnt = ecnt; v.econf = econf;
        return v;
    endfunction

    localparam int NV = 16;
    vec_t tbl [NV];

    initial begin
        // Directed sequence starting from reset with INIT_INDEX=1.
        tbl[0]  = mk(0,0,64'h0, 0,0,64'h0, 0,0,  5,31, 64'd5, 64'd31, 0,0,1, 0,0);
        tbl[1]  = mk(0,0,64'h0, 0,0,64'h0, 0,0,  0,1,  64'd0, 64'd1,  0,0,1, 0,0);
        tbl[2]  = mk(1,7,64'hDEAD_BEEF_0000_0001, 0,0,64'h0, 0,0, 7,0,
                     64'hDEAD_BEEF_0000_0001, 64'd0, 0,0,1, 0,0);
        tbl[3]  = mk(0,0,64'h0, 0,0,64'h0, 0,0,  7,6,  64'hDEAD_BEEF_0000_0001, 64'd6, 0,0,1, 0,0);
        tbl[4]  = mk(1,0,64'h55, 0,0,64'h0, 0,0, 0,7,  64'd0, 64'hDEAD_BEEF_0000_0001, 0,0,1, 0,0);
        tbl[5]  = mk(0,0,64'h0, 0,0,64'h0, 0,0,  0,2,  64'd0, 64'd2,  0,0,1, 0,0);
        tbl[6]  = mk(0,0,64'h0, 0,0,64'h0, 1,12, 12,12, 64'd12, 64'd12, 0,0,1, 1,0);
        tbl[7]  = mk(0,0,64'h0, 0,0,64'h0, 1,12, 12,3,  64'd12, 64'd3,  1,0,0, 1,0);
        tbl[8]  = mk(0,0,64'h0, 1,12,64'h42, 0,12, 12,12, 64'h42, 64'h42, 0,0,1, 0,0);
        tbl[9]  = mk(0,0,64'h0, 0,0,64'h0, 0,0,  12,0, 64'h42, 64'd0,  0,0,1, 0,0);
        tbl[10] = mk(0,0,64'h0, 0,0,64'h0, 1,9,  9,0,  64'd9,  64'd0,  0,0,1, 1,0);
        tbl[11] = mk(0,0,64'h0, 1,9,64'h99, 1,9,  9,9,  64'h99, 64'h99, 0,0,1, 1,0);
        tbl[12] = mk(0,0,64'h0, 0,0,64'h0, 0,9,  9,0,  64'h99, 64'd0,  1,0,0, 1,0);
        tbl[13] = mk(1,3,64'h11, 1,3,64'h22, 0,0, 3,9,  64'h22, 64'h99, 0,1,1, 1,1);
        tbl[14] = mk(0,0,64'h0, 0,0,64'h0, 0,0,  3,0,  64'h22, 64'd0,  0,0,1, 1,1);
        tbl[15] = mk(0,0,64'h0, 1,9,64'hAB, 0,0,  9,0,  64'hAB, 64'd0,  0,0,1, 0,1);

        drive(1, 0,0,64'h0, 0,0,64'h0, 0,0, 0,0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cnt",  64'(busy_cnt),    64'd0);
        chk("rst_conf", 64'(wr_conflict), 64'd0);
        @(negedge clk);
        model_reset();

        for (int i = 0; i < NV; i++) begin
            drive(0, tbl[i].w0en, tbl[i].w0rd, tbl[i].w0d, tbl[i].w1en, tbl[i].w1rd, tbl[i].w1d,
                  tbl[i].isen, tbl[i].isrd, tbl[i].a0, tbl[i].a1);
            #1;
            chk($sformatf("v%0d_rd0", i),   rs_data[63:0],   tbl[i].ed0);
            chk($sformatf("v%0d_rd1", i),   rs_data[127:64], tbl[i].ed1);
            chk($sformatf("v%0d_rb0", i),   64'(rs_busy[0]), 64'(tbl[i].eb0));
            chk($sformatf("v%0d_rb1", i),   64'(rs_busy[1]), 64'(tbl[i].eb1));
            chk($sformatf("v%0d_ok", i),    64'(iss_ok),     64'(tbl[i].eok));
            @(posedge clk);
            model_edge();
            #1;
            chk($sformatf("v%0d_cnt", i),   64'(busy_cnt),    64'(tbl[i].ecnt));
            chk($sformatf("v%0d_conf", i),  64'(wr_conflict), 64'(tbl[i].econf));
            @(negedge clk);
        end

        // Reset while three registers are busy and wr1 is active.
        cyc(0, 0,0,64'h0, 0,0,64'h0, 1,4, 4,5);
        cyc(0, 0,0,64'h0, 0,0,64'h0, 1,5, 4,5);
        cyc(0, 0,0,64'h0, 0,0,64'h0, 1,6, 4,6);
        chk("three_busy", 64'(busy_cnt), 64'd3);
        drive(1, 0,0,64'h0, 1,5,64'h77, 1,7, 5,3);
        @(posedge clk);
        model_edge();
        #1;
        chk("rst2_cnt",  64'(busy_cnt),    64'd0);
        chk("rst2_conf", 64'(wr_conflict), 64'd0);
        @(negedge clk);
        drive(0, 0,0,64'h0, 0,0,64'h0, 0,4, 5,3);
        #1;
        chk("rst2_rd5",  rs_data[63:0],   64'd5);
        chk("rst2_rd3",  rs_data[127:64], 64'd3);
        chk("rst2_rb5",  64'(rs_busy[0]), 64'd0);
        chk("rst2_ok4",  64'(iss_ok),     64'd1);
        drive(0, 0,0,64'h0, 0,0,64'h0, 0,6, 6,4);
        #1;
        chk("rst2_rb6",  64'(rs_busy[0]), 64'd0);
        chk("rst2_ok6",  64'(iss_ok),     64'd1);
        @(negedge clk);

        // Randomised traffic on a small register window to force collisions.
        for (int n = 0; n < 3000; n++) begin
            cyc($urandom_range(99) == 0,
                $urandom_range(1) == 1, int'($urandom_range(7)), {$urandom, $urandom},
                $urandom_range(2) == 0, int'($urandom_range(7)), {$urandom, $urandom},
                $urandom_range(1) == 1, int'($urandom_range(7)),
                int'($urandom_range(7)), int'($urandom_range(31)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
